// File: rtl/mult_add_tree_pkg.sv
// Shared helpers for the multiply-add tree: pipeline depth and the operand-count check.
package mult_add_tree_pkg;

    // One input-register stage, one product stage, then one adder stage per halving.
    function automatic int latency(input int num_inputs);
        return 1 + $clog2(num_inputs);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mult_add_tree_pipeline_pipe_stage_ctrl.sv
// Per-stage valid bit and advance term of the elastic pipeline.
module pipe_stage_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic v_prev,
    input  logic adv_next,
    output logic adv,
    output logic v
);

    logic v_q;
    logic v_d;

    // An empty stage always loads, so bubbles are squeezed out even while the output is stalled.
    always_comb begin
        adv = !v_q || adv_next;
        v_d = adv ? v_prev : v_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    assign v = v_q;

endmodule

// File: rtl/mult_add_tree_pipeline.sv
// Elastic pipelined multiply-add tree: out = sum of in[2i]*in[2i+1], truncated to WIDTH bits.
module mult_add_tree_pipeline
    import mult_add_tree_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 8,
    parameter int IS_SIGNED  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in [NUM_INPUTS],
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] out,
    output logic             valid_out,
    input  logic             ready_out
);

    localparam int LATENCY = latency(NUM_INPUTS);

    if (NUM_INPUTS < 2 || !is_pow2(NUM_INPUTS)) begin : g_bad_num_inputs
        $error("mult_add_tree_pipeline: NUM_INPUTS must be a power of 2 and >= 2");
    end

    // The low WIDTH bits of a product do not depend on signedness; the mode is kept explicit anyway.
    function automatic logic [WIDTH-1:0] mul_trunc(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] p;
        if (IS_SIGNED != 0) begin
            p = $signed(a) * $signed(b);
        end else begin
            p = a * b;
        end
        return p;
    endfunction

    logic [LATENCY-1:0] adv;

    // Ready ripples combinationally from ready_out back to ready_in through every stage.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic v_prev;
        logic adv_next;
        logic adv_k;
        logic v_k;

        if (k == 0) begin : g_first
            assign v_prev = valid_in;
        end else begin : g_mid
            assign v_prev = g_stage[k-1].v_k;
        end

        if (k == LATENCY - 1) begin : g_last
            assign adv_next = ready_out;
        end else begin : g_inner
            assign adv_next = g_stage[k+1].adv_k;
        end

        pipe_stage_ctrl u_ctrl (
            .clk      (clk),
            .rst      (rst),
            .v_prev   (v_prev),
            .adv_next (adv_next),
            .adv      (adv_k),
            .v        (v_k)
        );

        assign adv[k] = adv_k;
    end

    // Data registers load on every advance; an invalid slot just carries don't-care data.
    for (genvar lvl = 0; lvl < LATENCY; lvl++) begin : g_lvl
        localparam int NODES = NUM_INPUTS >> lvl;

        logic [WIDTH-1:0] node_q [NODES];
        logic [WIDTH-1:0] node_d [NODES];

        if (lvl == 0) begin : g_load
            always_comb begin
                for (int j = 0; j < NODES; j++) begin
                    node_d[j] = adv[lvl] ? in[j] : node_q[j];
                end
            end
        end else if (lvl == 1) begin : g_mul
            always_comb begin
                for (int j = 0; j < NODES; j++) begin
                    node_d[j] = adv[lvl] ? mul_trunc(g_lvl[0].node_q[2*j], g_lvl[0].node_q[2*j+1])
                                         : node_q[j];
                end
            end
        end else begin : g_add
            always_comb begin
                for (int j = 0; j < NODES; j++) begin
                    node_d[j] = adv[lvl] ? g_lvl[lvl-1].node_q[2*j] + g_lvl[lvl-1].node_q[2*j+1]
                                         : node_q[j];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < NODES; j++) begin
                    node_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j < NODES; j++) begin
                    node_q[j] <= node_d[j];
                end
            end
        end
    end

    assign ready_in  = adv[0];
    assign out       = g_lvl[LATENCY-1].node_q[0];
    assign valid_out = g_stage[LATENCY-1].v_k;

endmodule

// File: tb/tb_mult_add_tree_pipeline.sv
// Directed bench for the elastic multiply-add tree: N=8 unsigned, N=2 signed W=8, N=16 unsigned.
module tb_mult_add_tree_pipeline;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] in8 [8];
    logic        vin8, rin8, vout8, rout8;
    logic [15:0] out8;

    logic [7:0]  in2 [2];
    logic        vin2, rin2, vout2, rout2;
    logic [7:0]  out2;

    logic [15:0] in16 [16];
    logic        vin16, rin16, vout16, rout16;
    logic [15:0] out16;

    mult_add_tree_pipeline #(.WIDTH(16), .NUM_INPUTS(8), .IS_SIGNED(0)) u_dut8 (
        .clk(clk), .rst(rst), .in(in8), .valid_in(vin8), .ready_in(rin8),
        .out(out8), .valid_out(vout8), .ready_out(rout8)
    );

    mult_add_tree_pipeline #(.WIDTH(8), .NUM_INPUTS(2), .IS_SIGNED(1)) u_dut2 (
        .clk(clk), .rst(rst), .in(in2), .valid_in(vin2), .ready_in(rin2),
        .out(out2), .valid_out(vout2), .ready_out(rout2)
    );

    mult_add_tree_pipeline #(.WIDTH(16), .NUM_INPUTS(16), .IS_SIGNED(0)) u_dut16 (
        .clk(clk), .rst(rst), .in(in16), .valid_in(vin16), .ready_in(rin16),
        .out(out16), .valid_out(vout16), .ready_out(rout16)
    );

    typedef struct packed {
        logic [0:7][15:0] ops;
        logic [15:0]      exp;
    } vec8_t;

    vec8_t       vtab [7];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          in_cnt   = 0;
    int          out_cnt  = 0;
    logic        rin_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model8(input logic [15:0] a [8]);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + 32'(a[2*i]) * 32'(a[2*i+1]);
        end
        return acc[15:0];
    endfunction

    // Called right after a negedge with inputs set; samples 1ns later, then moves to next negedge.
    task automatic tick8(output logic fired, output logic [15:0] val);
        logic [15:0] e;
        #1;
        rin_s = rin8;
        fired = vout8 && rout8;
        val   = out8;
        if (vin8 && rin8) begin
            exp_q.push_back(model8(in8));
            in_cnt++;
        end
        if (fired) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_spurious: got result %0h expected no result at %0t", out8, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_out", out8, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_in8();
        for (int i = 0; i < 8; i++) begin
            in8[i] = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic drain8(input string name);
        logic        f;
        logic [15:0] v;
        int          n;
        vin8  = 1'b0;
        rout8 = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick8(f, v);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                        input string name);
        int   lat;
        logic found;
        in2[0] = a;
        in2[1] = b;
        vin2   = 1'b1;
        rout2  = 1'b1;
        #1;
        check({name, "_ready"}, rin2, 1);
        @(negedge clk);
        vin2  = 1'b0;
        found = 1'b0;
        for (lat = 1; lat <= 10; lat++) begin
            #1;
            if (vout2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_seen"}, found, 1);
        check({name, "_out"}, out2, exp);
        check({name, "_lat"}, lat, 2);
        @(negedge clk);
    endtask

    task automatic run16(input logic [15:0] base, input logic [15:0] step, input logic [15:0] exp,
                         input string name);
        int   lat;
        logic found;
        for (int i = 0; i < 16; i++) begin
            in16[i] = base + step * 16'(i);
        end
        vin16  = 1'b1;
        rout16 = 1'b1;
        @(negedge clk);
        vin16 = 1'b0;
        found = 1'b0;
        for (lat = 1; lat <= 12; lat++) begin
            #1;
            if (vout16) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_seen"}, found, 1);
        check({name, "_out"}, out16, exp);
        check({name, "_lat"}, lat, 5);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        f;
        logic [15:0] v;
        int          lat;
        int          ic, oc, n;
        logic        seen;

        vtab[0].ops = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        vtab[0].exp = 16'd100;
        vtab[1].ops = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vtab[1].exp = 16'd0;
        vtab[2].ops = {16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vtab[2].exp = 16'd1;
        vtab[3].ops = {16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        vtab[3].exp = 16'd140;
        vtab[4].ops = {16'h0100, 16'h0100, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        vtab[4].exp = 16'd3;
        vtab[5].ops = {16'h8000, 16'd2, 16'h8000, 16'd2, 16'd3, 16'h5555, 16'd0, 16'd7};
        vtab[5].exp = 16'hFFFF;
        vtab[6].ops = {16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000};
        vtab[6].exp = 16'd2304;

        // clock / reset
        rst = 1'b1;
        vin8 = 1'b0;  rout8 = 1'b1;
        vin2 = 1'b0;  rout2 = 1'b1;
        vin16 = 1'b0; rout16 = 1'b1;
        for (int i = 0; i < 8; i++)  in8[i]  = '0;
        for (int i = 0; i < 2; i++)  in2[i]  = '0;
        for (int i = 0; i < 16; i++) in16[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid_out8", vout8, 0);
        check("rst_out8", out8, 0);
        check("rst_ready_in8", rin8, 1);
        check("rst_valid_out2", vout2, 0);
        check("rst_ready_in16", rin16, 1);
        @(negedge clk);

        // single beats from the table: value, latency 4, then valid_out drops
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 8; i++) in8[i] = vtab[t].ops[i];
            vin8  = 1'b1;
            rout8 = 1'b1;
            tick8(f, v);
            vin8 = 1'b0;
            seen = 1'b0;
            for (lat = 1; lat <= 12; lat++) begin
                tick8(f, v);
                if (f) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("tab_seen", seen, 1);
            check("tab_out", v, vtab[t].exp);
            check("tab_lat", lat, 4);
            tick8(f, v);
            check("tab_valid_drop", f, 0);
        end

        // back-to-back streaming, 100 beats
        rout8 = 1'b1;
        oc = out_cnt;
        for (int b = 0; b < 100; b++) begin
            rand_in8();
            vin8 = 1'b1;
            tick8(f, v);
            check("stream_ready", rin_s, 1);
        end
        vin8 = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick8(f, v);
            n++;
        end
        check("stream_drain_cycles", n, 4);
        check("stream_count", out_cnt - oc, 100);

        // fill with ready_out low, single release, then random backpressure
        rout8 = 1'b0;
        vin8  = 1'b1;
        ic = in_cnt;
        for (int c = 0; c < 10; c++) begin
            rand_in8();
            tick8(f, v);
        end
        check("fill_accepted", in_cnt - ic, 4);
        check("fill_ready_low", rin_s, 0);
        #1;
        check("fill_valid_held", vout8, 1);
        check("fill_out_held", out8, exp_q[0]);
        ic = in_cnt;
        oc = out_cnt;
        rout8 = 1'b1;
        tick8(f, v);
        check("release_ready_comb", rin_s, 1);
        rout8 = 1'b0;
        repeat (3) tick8(f, v);
        check("release_one_in", in_cnt - ic, 1);
        check("release_one_out", out_cnt - oc, 1);
        for (int c = 0; c < 80; c++) begin
            rand_in8();
            vin8  = 1'($urandom_range(0, 1));
            rout8 = 1'($urandom_range(0, 1));
            tick8(f, v);
        end
        drain8("random_bp_drain");
        check("random_bp_balance", out_cnt, in_cnt);

        // 2-beat prefix, then alternating valid_in against a stalled output
        rout8 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            rand_in8();
            vin8 = 1'b1;
            tick8(f, v);
        end
        drain8("prefix_drain");
        rout8 = 1'b0;
        ic = in_cnt;
        for (int c = 0; c < 16; c++) begin
            rand_in8();
            vin8 = (c % 2 == 0);
            tick8(f, v);
        end
        vin8 = 1'b1;
        tick8(f, v);
        check("bubble_accepted", in_cnt - ic, 4);
        check("bubble_ready_low", rin_s, 0);
        drain8("bubble_drain");

        // signed, WIDTH=8, N=2
        run2(8'hFD, 8'h05, 8'hF1, "s2_neg3x5");
        run2(8'h10, 8'h10, 8'h00, "s2_wrap");
        run2(8'hFF, 8'hFF, 8'h01, "s2_neg1sq");
        run2(8'hF6, 8'h0A, 8'h9C, "s2_neg10x10");

        // N=16
        run16(16'd1, 16'd1, 16'd744, "n16_ramp");
        run16(16'hFFFF, 16'd0, 16'd8, "n16_ones");

        // reset with three results in flight and the output stalled
        rout8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_in8();
            vin8 = 1'b1;
            tick8(f, v);
        end
        vin8 = 1'b0;
        repeat (3) tick8(f, v);
        #1;
        check("inflight_valid", vout8, 1);
        check("inflight_count", exp_q.size(), 3);
        rst = 1'b1;
        #1;
        check("midrst_valid_out", vout8, 0);
        check("midrst_out", out8, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready_in", rin8, 1);
        @(negedge clk);
        rout8 = 1'b1;
        oc = out_cnt;
        repeat (10) tick8(f, v);
        check("midrst_no_stale", out_cnt - oc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
